// File: rtl/diffusion_sched_pkg.sv
// Shared FSM encoding and default parameter constants for the diffusion scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package diffusion_sched_pkg;

  localparam int N_ENG_DEF      = 4;
  localparam int ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_STEPS_DEF  = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Wrap an index that is at most 2*n-1 back into 0..n-1.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/diffusion_sched_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle to the first requester at or after the pointer.
// Latency: grant is combinational; the pointer moves to grant+1 on the following edge.
// Backpressure: losing requesters simply see no grant and must hold their request.
module rr_arbiter
  import diffusion_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  // Scan from the pointer, wrapping, and take the first requester found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'(wrap_idx(int'(ptr) + off, N));
      if (en && !grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer advances past the winner; it stays put on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= IW'(wrap_idx(int'(grant_idx) + 1, N));
    end
  end

endmodule

// File: rtl/diffusion_sched.sv
// Steps a bank of diffusion engines through max_steps launch/finish rounds and muxes their score writes.
// Latency: eng_rdy one cycle after start/advance; memory write one cycle after grant.
// Backpressure: engines not granted see eng_conflict and hold their request.
module diffusion_sched
  import diffusion_sched_pkg::*;
#(
  parameter int N_ENG      = N_ENG_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int max_steps  = MAX_STEPS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_ENG-1:0]            eng_finished,
  input  logic [N_ENG-1:0]            eng_req_s,
  input  logic [N_ENG*ADDR_WIDTH-1:0] eng_addr_s,
  input  logic [N_ENG*DATA_WIDTH-1:0] eng_data_s,
  output logic [N_ENG-1:0]            eng_rdy,
  output logic [N_ENG-1:0]            eng_conflict,
  output logic [DATA_WIDTH-1:0]       l_step,
  output logic [ADDR_WIDTH-1:0]       mem_addr_s,
  output logic [DATA_WIDTH-1:0]       mem_data_s,
  output logic                        mem_we_s,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

  state_t           state;
  logic [N_ENG-1:0] fin_latch;
  logic [N_ENG-1:0] fin_now;
  logic [N_ENG-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_vld;
  logic             in_run;

  assign in_run  = (state == ST_RUN);
  // Current-cycle finishes count toward the advance decision.
  assign fin_now = fin_latch | eng_finished;

  rr_arbiter #(.N(N_ENG)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (in_run),
    .req       (eng_req_s),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign eng_conflict = eng_req_s & ~grant & {N_ENG{in_run}};

  // Run sequencing: launch, wait for every engine, advance the step, repeat until the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      l_step    <= '0;
      fin_latch <= '0;
      eng_rdy   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      eng_rdy <= '0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LAUNCH;
            l_step  <= '0;
            busy    <= 1'b1;
            eng_rdy <= '1;
          end
        end
        ST_LAUNCH: begin
          // Finishes seen while launching belong to the previous step; drop them.
          fin_latch <= '0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          fin_latch <= fin_now;
          if (&fin_now) state <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (l_step == DATA_WIDTH'(max_steps - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            l_step  <= l_step + 1'b1;
            state   <= ST_LAUNCH;
            eng_rdy <= '1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shared memory port: register the granted engine's write; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_s <= '0;
      mem_data_s <= '0;
      mem_we_s   <= 1'b0;
    end else begin
      mem_we_s <= grant_vld;
      if (grant_vld) begin
        mem_addr_s <= eng_addr_s[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data_s <= eng_data_s[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
